// File: rtl/veritune_ctrl.sv
// Veritune record/shift/playback controller.
// Records audio samples into an internal buffer on Sample_En, hands off to the
// external pitch shifter, then plays the recording back once or looping.
// State is one-hot {q_Play,q_Shift,q_Stop,q_Rec,q_I}; any corrupted encoding
// falls back to I on the next clock.

module veritune_ctrl #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 17
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Rec,
    input  logic              Stop,
    input  logic              Play,
    input  logic              Loop,
    input  logic              Sample_En,
    input  logic              Done_Shift,
    input  logic [DATA_W-1:0] Audio_In,
    output logic [DATA_W-1:0] Audio_Out,
    output logic [ADDR_W:0]   Length,
    output logic              Full,
    output logic              Shift_Start,
    output logic              q_I,
    output logic              q_Rec,
    output logic              q_Stop,
    output logic              q_Shift,
    output logic              q_Play
);

    typedef enum logic [4:0] {
        S_I     = 5'b00001,
        S_REC   = 5'b00010,
        S_STOP  = 5'b00100,
        S_SHIFT = 5'b01000,
        S_PLAY  = 5'b10000
    } state_t;

    localparam logic [ADDR_W-1:0] IDX_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] IDX_LAST = {ADDR_W{1'b1}};
    localparam logic [ADDR_W:0]   LEN_ONE  = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   LEN_FULL = {1'b1, {ADDR_W{1'b0}}};

    // The state register is a plain vector rather than state_t so that a
    // corrupted (non one-hot) value is representable and can be recovered.
    logic [4:0]        state;
    logic [ADDR_W-1:0] index;
    logic [DATA_W-1:0] mem [0:(2**ADDR_W)-1];

    logic              rec_write;
    logic [ADDR_W:0]   rec_count;
    logic [ADDR_W:0]   last_index;
    logic              at_play_end;

    assign rec_write   = (state == S_REC) && Sample_En;
    assign rec_count   = {1'b0, index} + {{ADDR_W{1'b0}}, Sample_En};
    assign last_index  = Length - LEN_ONE;
    assign at_play_end = ({1'b0, index} == last_index);

    assign q_I     = state[0];
    assign q_Rec   = state[1];
    assign q_Stop  = state[2];
    assign q_Shift = state[3];
    assign q_Play  = state[4];

    // Sample buffer write port; kept free of reset so it maps onto block RAM.
    always_ff @(posedge Clk) begin
        if (rec_write) begin
            mem[index] <= Audio_In;
        end
    end

    // Controller FSM with registered index, length, flags and audio output.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state       <= S_I;
            index       <= '0;
            Length      <= '0;
            Full        <= 1'b0;
            Audio_Out   <= '0;
            Shift_Start <= 1'b0;
        end else begin
            Shift_Start <= 1'b0;
            if (state != S_PLAY) begin
                Audio_Out <= '0;
            end

            case (state)
                S_I: begin
                    if (Rec) begin
                        state <= S_REC;
                        index <= '0;
                        Full  <= 1'b0;
                    end
                end

                S_REC: begin
                    if (Sample_En && (index == IDX_LAST)) begin
                        state  <= S_STOP;
                        Length <= LEN_FULL;
                        Full   <= 1'b1;
                    end else begin
                        if (Sample_En) begin
                            index <= index + IDX_ONE;
                        end
                        if (Stop) begin
                            state  <= S_STOP;
                            Length <= rec_count;
                        end
                    end
                end

                S_STOP: begin
                    if (Rec) begin
                        state <= S_REC;
                        index <= '0;
                        Full  <= 1'b0;
                    end else if (Play && (Length != '0)) begin
                        state       <= S_SHIFT;
                        Shift_Start <= 1'b1;
                    end
                end

                S_SHIFT: begin
                    if (Stop) begin
                        state <= S_STOP;
                    end else if (Done_Shift) begin
                        state <= S_PLAY;
                        index <= '0;
                    end
                end

                S_PLAY: begin
                    if (Stop) begin
                        state <= S_STOP;
                    end else if (Sample_En) begin
                        Audio_Out <= mem[index];
                        if (at_play_end) begin
                            if (Loop) begin
                                index <= '0;
                            end else begin
                                state <= S_STOP;
                            end
                        end else begin
                            index <= index + IDX_ONE;
                        end
                    end
                end

                default: begin
                    state <= S_I;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_veritune_ctrl.sv
// Self-checking bench for veritune_ctrl with a 16-entry buffer.
// A table of single-cycle vectors covers record, shift, playback and the
// priority rules; hand-written sequences cover the full-buffer recording,
// asynchronous reset during playback and recovery from an illegal state.

module tb_veritune_ctrl;

    localparam int DATA_W = 16;
    localparam int ADDR_W = 4;

    localparam logic [4:0] ST_I     = 5'b00001;
    localparam logic [4:0] ST_REC   = 5'b00010;
    localparam logic [4:0] ST_STOP  = 5'b00100;
    localparam logic [4:0] ST_SHIFT = 5'b01000;
    localparam logic [4:0] ST_PLAY  = 5'b10000;

    logic              Clk = 1'b0;
    logic              Reset;
    logic              Rec;
    logic              Stop;
    logic              Play;
    logic              Loop;
    logic              Sample_En;
    logic              Done_Shift;
    logic [DATA_W-1:0] Audio_In;
    logic [DATA_W-1:0] Audio_Out;
    logic [ADDR_W:0]   Length;
    logic              Full;
    logic              Shift_Start;
    logic              q_I;
    logic              q_Rec;
    logic              q_Stop;
    logic              q_Shift;
    logic              q_Play;
    logic [4:0]        flags;

    int checks = 0;
    int passes = 0;

    typedef struct {
        logic              rec;
        logic              stop;
        logic              play;
        logic              loop;
        logic              se;
        logic              ds;
        logic [DATA_W-1:0] ain;
        logic [4:0]        st;
        logic [DATA_W-1:0] aout;
        logic [ADDR_W:0]   len;
        logic              full;
        logic              ss;
    } vec_t;

    vec_t vecs[$];

    assign flags = {q_Play, q_Shift, q_Stop, q_Rec, q_I};

    veritune_ctrl #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W)
    ) dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .Rec        (Rec),
        .Stop       (Stop),
        .Play       (Play),
        .Loop       (Loop),
        .Sample_En  (Sample_En),
        .Done_Shift (Done_Shift),
        .Audio_In   (Audio_In),
        .Audio_Out  (Audio_Out),
        .Length     (Length),
        .Full       (Full),
        .Shift_Start(Shift_Start),
        .q_I        (q_I),
        .q_Rec      (q_Rec),
        .q_Stop     (q_Stop),
        .q_Shift    (q_Shift),
        .q_Play     (q_Play)
    );

    // Free-running 100 MHz clock.
    always #5 Clk = ~Clk;

    function automatic vec_t mk(input logic rec, input logic stop, input logic play,
                                input logic loop, input logic se, input logic ds,
                                input logic [DATA_W-1:0] ain);
        vec_t v;
        v.rec  = rec;
        v.stop = stop;
        v.play = play;
        v.loop = loop;
        v.se   = se;
        v.ds   = ds;
        v.ain  = ain;
        v.st   = '0;
        v.aout = '0;
        v.len  = '0;
        v.full = 1'b0;
        v.ss   = 1'b0;
        return v;
    endfunction

    function automatic void addVec(input logic rec, input logic stop, input logic play,
                                   input logic loop, input logic se, input logic ds,
                                   input logic [DATA_W-1:0] ain, input logic [4:0] st,
                                   input logic [DATA_W-1:0] aout, input logic [ADDR_W:0] len,
                                   input logic full, input logic ss);
        vec_t v;
        v      = mk(rec, stop, play, loop, se, ds, ain);
        v.st   = st;
        v.aout = aout;
        v.len  = len;
        v.full = full;
        v.ss   = ss;
        vecs.push_back(v);
    endfunction

    // Drive one cycle of inputs, then sample just after the rising edge.
    task automatic applyStimulus(input vec_t v);
        Rec        = v.rec;
        Stop       = v.stop;
        Play       = v.play;
        Loop       = v.loop;
        Sample_En  = v.se;
        Done_Shift = v.ds;
        Audio_In   = v.ain;
        @(posedge Clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual === expected) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkVec(input string tag, input vec_t v);
        checkOutput({tag, " state"},       32'(flags),       32'(v.st));
        checkOutput({tag, " Audio_Out"},   32'(Audio_Out),   32'(v.aout));
        checkOutput({tag, " Length"},      32'(Length),      32'(v.len));
        checkOutput({tag, " Full"},        32'(Full),        32'(v.full));
        checkOutput({tag, " Shift_Start"}, 32'(Shift_Start), 32'(v.ss));
    endtask

    task automatic step(input logic rec, input logic stop, input logic play,
                        input logic loop, input logic se, input logic ds,
                        input logic [DATA_W-1:0] ain);
        applyStimulus(mk(rec, stop, play, loop, se, ds, ain));
    endtask

    // Main test sequence.
    initial begin
        // rec stop play loop se ds ain | state aout len full ss
        addVec(1, 0, 0, 0, 0, 0, 16'h0000, ST_REC, 16'h0000, 5'd0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            addVec(0, 0, 0, 0, 1, 0, 16'(16'h0011 * k), ST_REC, 16'h0000, 5'd0, 0, 0);
        end
        addVec(0, 0, 0, 0, 0, 0, 16'h0000, ST_REC,   16'h0000, 5'd0, 0, 0);
        addVec(0, 1, 0, 0, 0, 0, 16'h0000, ST_STOP,  16'h0000, 5'd5, 0, 0);
        addVec(0, 0, 1, 0, 0, 0, 16'h0000, ST_SHIFT, 16'h0000, 5'd5, 0, 1);
        addVec(0, 0, 0, 0, 0, 0, 16'h0000, ST_SHIFT, 16'h0000, 5'd5, 0, 0);
        addVec(0, 0, 0, 0, 0, 1, 16'h0000, ST_PLAY,  16'h0000, 5'd5, 0, 0);
        addVec(0, 0, 0, 0, 1, 0, 16'h0000, ST_PLAY,  16'h0011, 5'd5, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 16'h0000, ST_PLAY,  16'h0011, 5'd5, 0, 0);
        addVec(0, 0, 0, 0, 1, 0, 16'h0000, ST_PLAY,  16'h0022, 5'd5, 0, 0);
        addVec(0, 0, 0, 0, 1, 0, 16'h0000, ST_PLAY,  16'h0033, 5'd5, 0, 0);
        addVec(0, 0, 0, 0, 1, 0, 16'h0000, ST_PLAY,  16'h0044, 5'd5, 0, 0);
        addVec(0, 0, 0, 0, 1, 0, 16'h0000, ST_STOP,  16'h0055, 5'd5, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 16'h0000, ST_STOP,  16'h0000, 5'd5, 0, 0);
        addVec(0, 0, 1, 1, 0, 0, 16'h0000, ST_SHIFT, 16'h0000, 5'd5, 0, 1);
        addVec(0, 0, 0, 1, 0, 1, 16'h0000, ST_PLAY,  16'h0000, 5'd5, 0, 0);
        for (int k = 0; k < 12; k++) begin
            addVec(0, 0, 0, 1, 1, 0, 16'h0000, ST_PLAY, 16'(16'h0011 * ((k % 5) + 1)), 5'd5, 0, 0);
        end
        addVec(0, 1, 0, 1, 1, 0, 16'h0000, ST_STOP,  16'h0022, 5'd5, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 16'h0000, ST_STOP,  16'h0000, 5'd5, 0, 0);
        addVec(0, 0, 1, 0, 0, 0, 16'h0000, ST_SHIFT, 16'h0000, 5'd5, 0, 1);
        addVec(0, 1, 0, 0, 0, 1, 16'h0000, ST_STOP,  16'h0000, 5'd5, 0, 0);
        addVec(1, 0, 1, 0, 0, 0, 16'h0000, ST_REC,   16'h0000, 5'd5, 0, 0);
        addVec(0, 1, 0, 0, 1, 0, 16'h00AA, ST_STOP,  16'h0000, 5'd1, 0, 0);
        addVec(0, 0, 1, 0, 0, 0, 16'h0000, ST_SHIFT, 16'h0000, 5'd1, 0, 1);
        addVec(0, 0, 0, 0, 0, 1, 16'h0000, ST_PLAY,  16'h0000, 5'd1, 0, 0);
        addVec(0, 0, 0, 0, 1, 0, 16'h0000, ST_STOP,  16'h00AA, 5'd1, 0, 0);
        addVec(0, 0, 0, 0, 0, 0, 16'h0000, ST_STOP,  16'h0000, 5'd1, 0, 0);
        addVec(1, 0, 0, 0, 0, 0, 16'h0000, ST_REC,   16'h0000, 5'd1, 0, 0);
        addVec(0, 1, 0, 0, 0, 0, 16'h0000, ST_STOP,  16'h0000, 5'd0, 0, 0);
        addVec(0, 0, 1, 0, 0, 0, 16'h0000, ST_STOP,  16'h0000, 5'd0, 0, 0);

        Reset = 1'b1;
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 16'h0000));
        applyStimulus(mk(0, 0, 0, 0, 0, 0, 16'h0000));
        checkOutput("reset state",       32'(flags),       32'(ST_I));
        checkOutput("reset Audio_Out",   32'(Audio_Out),   32'h0);
        checkOutput("reset Length",      32'(Length),      32'h0);
        checkOutput("reset Full",        32'(Full),        32'h0);
        checkOutput("reset Shift_Start", 32'(Shift_Start), 32'h0);
        Reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i]);
            checkVec($sformatf("vec%0d", i), vecs[i]);
        end

        // Full-buffer recording stops by itself at DEPTH samples.
        step(1, 0, 0, 0, 0, 0, 16'h0000);
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 0, 1, 0, 16'(16'h0100 + i));
            if (i == 14) begin
                checkOutput("full rec 15th state", 32'(flags), 32'(ST_REC));
            end
        end
        checkOutput("full rec state",  32'(flags),  32'(ST_STOP));
        checkOutput("full rec Length", 32'(Length), 32'd16);
        checkOutput("full rec Full",   32'(Full),   32'd1);
        step(0, 0, 0, 0, 1, 0, 16'hDEAD);
        checkOutput("strobe in STOP state",  32'(flags),  32'(ST_STOP));
        checkOutput("strobe in STOP Length", 32'(Length), 32'd16);

        // Play the full buffer back once, including the last sample slot.
        step(0, 0, 1, 0, 0, 0, 16'h0000);
        checkOutput("full play Shift_Start", 32'(Shift_Start), 32'd1);
        step(0, 0, 0, 0, 0, 1, 16'h0000);
        checkOutput("full play enter", 32'(flags), 32'(ST_PLAY));
        for (int i = 0; i < 16; i++) begin
            step(0, 0, 0, 0, 1, 0, 16'h0000);
            checkOutput($sformatf("full play sample%0d", i), 32'(Audio_Out), 32'(16'h0100 + i));
        end
        checkOutput("full play end state", 32'(flags), 32'(ST_STOP));
        checkOutput("full play end Full",  32'(Full),  32'd1);
        step(0, 0, 0, 0, 0, 0, 16'h0000);
        checkOutput("full play end Audio_Out", 32'(Audio_Out), 32'h0);

        // Asynchronous reset between clock edges during looping playback.
        step(0, 0, 1, 1, 0, 0, 16'h0000);
        step(0, 0, 0, 1, 0, 1, 16'h0000);
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 1, 1, 0, 16'h0000);
        end
        checkOutput("pre-reset Audio_Out", 32'(Audio_Out), 32'h0102);
        #3;
        Reset = 1'b1;
        #1;
        checkOutput("async reset state",     32'(flags),     32'(ST_I));
        checkOutput("async reset Audio_Out", 32'(Audio_Out), 32'h0);
        checkOutput("async reset Length",    32'(Length),    32'h0);
        checkOutput("async reset Full",      32'(Full),      32'h0);
        #2;
        Reset = 1'b0;
        step(0, 0, 0, 0, 0, 0, 16'h0000);
        checkOutput("post-reset idle state", 32'(flags), 32'(ST_I));

        // Corrupted one-hot state recovers to I on the next clock.
        #2;
        force dut.state = 5'b00011;
        #1;
        checkOutput("illegal state forced", 32'(flags), 32'h03);
        release dut.state;
        step(0, 0, 0, 0, 0, 0, 16'h0000);
        checkOutput("illegal state recovery", 32'(flags), 32'(ST_I));

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
